// File: rtl/vtime_pkg.sv
// Shared constants and state encoding for the vtime_gen periodic strobe generator.
package vtime_pkg;

    localparam int unsigned VT_W        = 16;
    localparam int unsigned VT_PRESCALE = 64;
    localparam int unsigned PS_W        = $clog2(VT_PRESCALE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : vtime_pkg

// File: rtl/vtime_prescaler.sv
// Free-running divide-by-PRESCALE counter; tick is high on the cycle the count wraps.
module vtime_prescaler
    import vtime_pkg::*;
#(
    parameter int unsigned PRESCALE = VT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule : vtime_prescaler

// File: rtl/vtime_gen.sv
// Periodic strobe generator: one-clk pulse on x every cur_period*PRESCALE clocks.
// Define VTIME_GEN_BURST_EN to add burst_len/done and stop after a fixed pulse count.
module vtime_gen
    import vtime_pkg::*;
#(
    parameter int unsigned W        = VT_W,
    parameter int unsigned PRESCALE = VT_PRESCALE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] period,
`ifdef VTIME_GEN_BURST_EN
    input  logic [7:0]   burst_len,
    output logic         done,
`endif
    output logic         x,
    output logic         busy,
    output logic [W-1:0] cur_period
);

    state_e       state_q, state_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] unit_q, unit_d;
    logic [W-1:0] cur_q, cur_d;
    logic         x_q, x_d;
    logic         busy_q, busy_d;

    logic tick;
    logic ps_clr;
    logic term;
    logic start_ok;
    logic burst_last;
    logic arm_ok;

    // Counters are held clear outside RUN and flushed the moment en drops.
    assign ps_clr = (state_q != RUN) || !en;

    vtime_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (ps_clr),
        .tick (tick)
    );

    assign term     = (state_q == RUN) && tick && (unit_q == cur_q - W'(1));
    assign start_ok = ld ? (period != '0) : ((shadow_q != '0) && arm_ok);

    always_comb begin
        state_d  = state_q;
        shadow_d = ld ? period : shadow_q;
        unit_d   = unit_q;
        cur_d    = cur_q;
        x_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && start_ok) begin
                    state_d = RUN;
                    cur_d   = ld ? period : shadow_q;
                end
            end
            RUN: begin
                // Period boundary: the shadow value from before this edge takes over.
                if (term) begin
                    x_d   = 1'b1;
                    cur_d = shadow_q;
                    if ((shadow_q == '0) || burst_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ps_clr) begin
            unit_d = '0;
        end else if (tick) begin
            unit_d = term ? '0 : unit_q + W'(1);
        end

        if (!en) begin
            state_d = IDLE;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            unit_q   <= '0;
            cur_q    <= '0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            unit_q   <= unit_d;
            cur_q    <= cur_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
        end
    end

    assign x          = x_q;
    assign busy       = busy_q;
    assign cur_period = cur_q;

`ifdef VTIME_GEN_BURST_EN
    logic [7:0] blen_q, blen_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       armed_q, armed_d;
    logic       done_q, done_d;

    assign burst_last = (blen_q != 8'd0) && (bcnt_q == blen_q - 8'd1);
    assign arm_ok     = armed_q;

    // Pulse counter for bursts; a completed burst disarms until the next ld.
    always_comb begin
        blen_d  = blen_q;
        bcnt_d  = bcnt_q;
        armed_d = armed_q;
        done_d  = 1'b0;

        if (state_q != RUN) begin
            bcnt_d = '0;
        end else if (term && (blen_q != 8'd0)) begin
            if (burst_last) begin
                done_d  = 1'b1;
                armed_d = 1'b0;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end

        if (ld) begin
            blen_d  = burst_len;
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blen_q  <= '0;
            bcnt_q  <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            blen_q  <= blen_d;
            bcnt_q  <= bcnt_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
`else
    assign burst_last = 1'b0;
    assign arm_ok     = 1'b1;
`endif

endmodule : vtime_gen

// File: tb/tb_vtime_gen.sv
// Scoreboard bench for vtime_gen: an event-time model predicts pulse cycles, a monitor checks them.
module tb_vtime_gen;

    localparam int PS = 64;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [15:0] period;
    logic        x;
    logic        busy;
    logic [15:0] cur_period;
`ifdef VTIME_GEN_BURST_EN
    logic [7:0]  burst_len;
    logic        done;
`endif

    vtime_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ld        (ld),
        .period    (period),
`ifdef VTIME_GEN_BURST_EN
        .burst_len (burst_len),
        .done      (done),
`endif
        .x         (x),
        .busy      (busy),
        .cur_period(cur_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   seen_q[$];
    int   done_seen[$];
    exp_t mon_e;

    int n        = 0;
    int checks   = 0;
    int failures = 0;

    // Reference model: whether a period is running, when its pulse lands, and the loaded values.
    bit run_m    = 0;
    int nxt_m    = 0;
    int cur_m    = 0;
    int shadow_m = 0;
    int blen_m   = 0;
    int bcnt_m   = 0;
    bit armed_m  = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, n);
        end
    endtask

    function automatic int seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return -1;
    endfunction

    // Apply the inputs sampled at edge n to the model.
    task automatic model_edge();
        bit   was_run;
        bit   last;
        bit   can_start;
        int   old_sh;
        int   p;
        exp_t ne;
        if (!rst_n) begin
            run_m = 0; cur_m = 0; shadow_m = 0;
            blen_m = 0; bcnt_m = 0; armed_m = 0;
            exp_q.delete();
            return;
        end
        was_run = run_m;
        old_sh  = shadow_m;
        p       = int'(period);
        last    = 0;
        if (was_run && nxt_m == n) begin
`ifdef VTIME_GEN_BURST_EN
            if (blen_m != 0) begin
                if (bcnt_m + 1 == blen_m) begin
                    last    = 1;
                    armed_m = 0;
                end else begin
                    bcnt_m++;
                end
            end
`endif
            ne.cyc  = n;
            ne.done = last;
            exp_q.push_back(ne);
            cur_m = old_sh;
            if (old_sh == 0 || last) run_m = 0;
            else nxt_m = n + old_sh * PS;
        end else if (!was_run && en) begin
            can_start = ld ? (p != 0) : (old_sh != 0);
`ifdef VTIME_GEN_BURST_EN
            if (!ld && !armed_m) can_start = 0;
`endif
            if (can_start) begin
                cur_m  = ld ? p : old_sh;
                run_m  = 1;
                nxt_m  = n + cur_m * PS;
                bcnt_m = 0;
            end
        end
        if (!en) run_m = 0;
        if (ld) begin
            shadow_m = p;
            armed_m  = 1;
`ifdef VTIME_GEN_BURST_EN
            blen_m   = int'(burst_len);
`endif
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        n = n + 1;
        model_edge();
        #1;
    endtask

    // Monitor: sample away from the active edge and retire expected pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", longint'(busy), longint'(run_m));
            chk("cur_period", longint'(cur_period), longint'(cur_m));
            if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
                mon_e = exp_q.pop_front();
                chk("x_pulse", longint'(x), 1);
`ifdef VTIME_GEN_BURST_EN
                chk("done_with_x", longint'(done), longint'(mon_e.done));
`endif
            end else begin
                chk("x_quiet", longint'(x), 0);
`ifdef VTIME_GEN_BURST_EN
                chk("done_quiet", longint'(done), 0);
`endif
            end
            if (x) seen_q.push_back(n);
`ifdef VTIME_GEN_BURST_EN
            if (done) done_seen.push_back(n);
`endif
        end
    end

    int k;
    int s;
    int r;

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        ld     = 1'b0;
        period = '0;
`ifdef VTIME_GEN_BURST_EN
        burst_len = '0;
`endif
        repeat (3) tick_cycle();
        chk("reset_x", longint'(x), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_cur", longint'(cur_period), 0);
        rst_n = 1'b1;
        tick_cycle();

        // Start from idle with period 3: pulses every 192 clks after the ld edge.
        seen_q.delete();
        en = 1'b1; ld = 1'b1; period = 16'd3;
        tick_cycle();
        k  = n;
        ld = 1'b0;
        repeat (600) tick_cycle();
        chk("t2_count", seen_q.size(), 3);
        chk("t2_p0", seen_at(0), k + 192);
        chk("t2_p1", seen_at(1), k + 384);
        chk("t2_p2", seen_at(2), k + 576);

        // Reload mid-period: current period finishes, the new one follows.
        en = 1'b0;
        tick_cycle();
        en = 1'b1; ld = 1'b1; period = 16'd2;
        tick_cycle();
        s  = n;
        ld = 1'b0;
        seen_q.delete();
        repeat (99) tick_cycle();
        ld = 1'b1; period = 16'd5;
        tick_cycle();
        ld = 1'b0;
        repeat (360) tick_cycle();
        chk("t3_count", seen_q.size(), 2);
        chk("t3_p0", seen_at(0), s + 128);
        chk("t3_p1", seen_at(1), s + 448);

        // Loading zero: one final pulse at the boundary, then idle.
        en = 1'b0;
        tick_cycle();
        en = 1'b1; ld = 1'b1; period = 16'd1;
        tick_cycle();
        s  = n;
        ld = 1'b0;
        seen_q.delete();
        repeat (70) tick_cycle();
        ld = 1'b1; period = 16'd0;
        tick_cycle();
        ld = 1'b0;
        repeat (229) tick_cycle();
        chk("t4_count", seen_q.size(), 2);
        chk("t4_p0", seen_at(0), s + 64);
        chk("t4_p1", seen_at(1), s + 128);
        chk("t4_busy", longint'(busy), 0);

        // Drop en shortly before a pulse, then re-enable.
        en = 1'b0;
        tick_cycle();
        en = 1'b1; ld = 1'b1; period = 16'd2;
        tick_cycle();
        s  = n;
        ld = 1'b0;
        seen_q.delete();
        repeat (117) tick_cycle();
        en = 1'b0;
        tick_cycle();
        chk("t5_busy_off", longint'(busy), 0);
        repeat (20) tick_cycle();
        chk("t5_no_x", seen_q.size(), 0);
        en = 1'b1;
        tick_cycle();
        r = n;
        repeat (140) tick_cycle();
        chk("t5_count", seen_q.size(), 1);
        chk("t5_p0", seen_at(0), r + 128);

`ifdef VTIME_GEN_BURST_EN
        // Burst of three pulses, done with the last, then stay idle.
        en = 1'b0;
        tick_cycle();
        en = 1'b1; ld = 1'b1; period = 16'd1; burst_len = 8'd3;
        tick_cycle();
        s  = n;
        ld = 1'b0; burst_len = 8'd0;
        seen_q.delete();
        done_seen.delete();
        repeat (300) tick_cycle();
        chk("t6_count", seen_q.size(), 3);
        chk("t6_p0", seen_at(0), s + 64);
        chk("t6_p1", seen_at(1), s + 128);
        chk("t6_p2", seen_at(2), s + 192);
        chk("t6_done_count", done_seen.size(), 1);
        chk("t6_done_at", (done_seen.size() != 0) ? done_seen[0] : -1, s + 192);
        chk("t6_busy", longint'(busy), 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            en     = ($urandom_range(0, 99) < 97);
            ld     = ($urandom_range(0, 99) < 2);
            period = 16'($urandom_range(0, 4));
`ifdef VTIME_GEN_BURST_EN
            burst_len = 8'($urandom_range(0, 3));
`endif
            tick_cycle();
        end
        ld = 1'b0;

        // Asynchronous reset in the middle of a running period.
        en = 1'b0;
        tick_cycle();
        en = 1'b1; ld = 1'b1; period = 16'd2;
`ifdef VTIME_GEN_BURST_EN
        burst_len = 8'd0;
`endif
        tick_cycle();
        ld = 1'b0;
        repeat (30) tick_cycle();
        chk("t1_running", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_x", longint'(x), 0);
        chk("t1_busy", longint'(busy), 0);
        chk("t1_cur", longint'(cur_period), 0);
        repeat (2) tick_cycle();
        rst_n = 1'b1;
        seen_q.delete();
        repeat (200) tick_cycle();
        chk("t1_no_x_after_reset", seen_q.size(), 0);
        chk("t1_idle_after_reset", longint'(busy), 0);
        chk("pending_pulses", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vtime_gen
